// File: rtl/i2c_cmd_arbiter.sv
// Shares one I2C byte-transfer controller between the codec config sequencer (req0) and the
// runtime register writer (req1): work-clock divider, arbitration, NACK retry, timeout, status.
module i2c_cmd_arbiter #(
    parameter int CLK_Freq  = 50000000,
    parameter int I2C_Freq  = 20000,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 64,
    parameter int RR_EN     = 1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        iREQ0_VALID,
    input  logic [23:0] iREQ0_DATA,
    output logic        oREQ0_READY,
    output logic        oREQ0_DONE,
    output logic        oREQ0_ERR,
    input  logic        iREQ1_VALID,
    input  logic [23:0] iREQ1_DATA,
    output logic        oREQ1_READY,
    output logic        oREQ1_DONE,
    output logic        oREQ1_ERR,
    output logic        oI2C_CTRL_CLK,
    output logic [23:0] oI2C_DATA,
    output logic        oI2C_GO,
    input  logic        iI2C_END,
    input  logic        iI2C_ACK,
    output logic        oBUSY
);

    localparam int DIV_TC = CLK_Freq / I2C_Freq;
    localparam int DIV_W  = (DIV_TC < 2) ? 1 : $clog2(DIV_TC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [DIV_W-1:0] r_div;
    logic             r_ctrlClk;
    logic [23:0]      r_data;
    logic [23:0]      w_dataNext;
    logic             r_go;
    logic             w_goNext;
    logic [2:0]       r_retry;
    logic [2:0]       w_retryNext;
    logic [7:0]       r_tmo;
    logic [7:0]       w_tmoNext;
    logic             r_err;
    logic             w_errNext;
    logic             r_owner;
    logic             w_ownerNext;
    logic             r_rrPtr;
    logic             w_rrPtrNext;
    logic             w_strobe;
    logic             w_anyValid;
    logic             w_grant1;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_done;

    // The strobe is the last iCLK cycle before the work clock rises.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_div     <= '0;
            r_ctrlClk <= 1'b0;
        end else if (r_div == DIV_W'(DIV_TC)) begin
            r_div     <= '0;
            r_ctrlClk <= ~r_ctrlClk;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    assign w_strobe   = (r_div == DIV_W'(DIV_TC)) && !r_ctrlClk;
    assign w_anyValid = iREQ0_VALID || iREQ1_VALID;
    assign w_grant1   = (RR_EN != 0) ? (iREQ1_VALID && (!iREQ0_VALID || r_rrPtr))
                                     : (iREQ1_VALID && !iREQ0_VALID);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_go    <= 1'b0;
            r_retry <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
            r_owner <= 1'b0;
            r_rrPtr <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_data  <= w_dataNext;
            r_go    <= w_goNext;
            r_retry <= w_retryNext;
            r_tmo   <= w_tmoNext;
            r_err   <= w_errNext;
            r_owner <= w_ownerNext;
            r_rrPtr <= w_rrPtrNext;
        end
    end

    // END is checked before the timeout so a late completion still wins on the same strobe.
    always_comb begin
        w_stateNext = r_state;
        w_dataNext  = r_data;
        w_goNext    = r_go;
        w_retryNext = r_retry;
        w_tmoNext   = r_tmo;
        w_errNext   = r_err;
        w_ownerNext = r_owner;
        w_rrPtrNext = r_rrPtr;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_done      = 1'b0;
        if (w_strobe) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_anyValid) begin
                        w_ownerNext = w_grant1;
                        w_dataNext  = w_grant1 ? iREQ1_DATA : iREQ0_DATA;
                        w_ready0    = !w_grant1;
                        w_ready1    = w_grant1;
                        w_goNext    = 1'b1;
                        w_retryNext = '0;
                        w_tmoNext   = '0;
                        w_errNext   = 1'b0;
                        w_stateNext = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (iI2C_END) begin
                        w_goNext = 1'b0;
                        if (!iI2C_ACK) begin
                            w_errNext   = 1'b0;
                            w_stateNext = S_DONE;
                        end else if (r_retry < 3'(MAX_RETRY)) begin
                            w_retryNext = r_retry + 3'd1;
                            w_stateNext = S_GAP;
                        end else begin
                            w_errNext   = 1'b1;
                            w_stateNext = S_DONE;
                        end
                    end else if (r_tmo == 8'(TIMEOUT - 1)) begin
                        w_goNext    = 1'b0;
                        w_errNext   = 1'b1;
                        w_stateNext = S_DONE;
                    end else begin
                        w_tmoNext = r_tmo + 8'd1;
                    end
                end
                S_GAP: begin
                    w_goNext    = 1'b1;
                    w_tmoNext   = '0;
                    w_stateNext = S_WAIT;
                end
                S_DONE: begin
                    w_done      = 1'b1;
                    w_rrPtrNext = ~r_owner;
                    w_stateNext = S_IDLE;
                end
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    assign oREQ0_READY   = w_ready0;
    assign oREQ1_READY   = w_ready1;
    assign oREQ0_DONE    = w_done && !r_owner;
    assign oREQ1_DONE    = w_done && r_owner;
    assign oREQ0_ERR     = w_done && !r_owner && r_err;
    assign oREQ1_ERR     = w_done && r_owner && r_err;
    assign oI2C_CTRL_CLK = r_ctrlClk;
    assign oI2C_DATA     = r_data;
    assign oI2C_GO       = r_go;
    assign oBUSY         = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Randomized bench for i2c_cmd_arbiter: a behavioural I2C controller drives END/ACK and a
// transaction-level model predicts grant order, GO count/length and ERR for every command.
module tb_i2c_cmd_arbiter;

    localparam int CLK_F     = 4;
    localparam int I2C_F     = 1;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 64;
    localparam int CLKP      = 10;

    logic        iCLK, iRST_N;
    logic        iREQ0_VALID, iREQ1_VALID;
    logic [23:0] iREQ0_DATA, iREQ1_DATA;
    logic        oREQ0_READY, oREQ0_DONE, oREQ0_ERR;
    logic        oREQ1_READY, oREQ1_DONE, oREQ1_ERR;
    logic        oI2C_CTRL_CLK, oI2C_GO, oBUSY;
    logic [23:0] oI2C_DATA;
    logic        iI2C_END, iI2C_ACK;

    logic        fV0, fV1, fReady0, fReady1, fDone0, fDone1, fErr0, fErr1;
    logic        fCtrl, fGo, fBusy, fEnd, fAck;
    logic [23:0] fD0, fD1, fData;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          ctlDelay = 1;
    int          ctlNacks = 0;
    bit          ctlNeverEnd = 0;
    int          goRises = 0;
    int          lastGoLen = 0;
    logic [23:0] riseData = '0;
    logic        prio = 1'b0;

    i2c_cmd_arbiter #(.CLK_Freq(CLK_F), .I2C_Freq(I2C_F), .MAX_RETRY(MAX_RETRY),
                      .TIMEOUT(TIMEOUT), .RR_EN(1)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iREQ0_VALID(iREQ0_VALID), .iREQ0_DATA(iREQ0_DATA), .oREQ0_READY(oREQ0_READY),
        .oREQ0_DONE(oREQ0_DONE), .oREQ0_ERR(oREQ0_ERR),
        .iREQ1_VALID(iREQ1_VALID), .iREQ1_DATA(iREQ1_DATA), .oREQ1_READY(oREQ1_READY),
        .oREQ1_DONE(oREQ1_DONE), .oREQ1_ERR(oREQ1_ERR),
        .oI2C_CTRL_CLK(oI2C_CTRL_CLK), .oI2C_DATA(oI2C_DATA), .oI2C_GO(oI2C_GO),
        .iI2C_END(iI2C_END), .iI2C_ACK(iI2C_ACK), .oBUSY(oBUSY)
    );

    i2c_cmd_arbiter #(.CLK_Freq(CLK_F), .I2C_Freq(I2C_F), .MAX_RETRY(MAX_RETRY),
                      .TIMEOUT(TIMEOUT), .RR_EN(0)) dutFixed (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iREQ0_VALID(fV0), .iREQ0_DATA(fD0), .oREQ0_READY(fReady0),
        .oREQ0_DONE(fDone0), .oREQ0_ERR(fErr0),
        .iREQ1_VALID(fV1), .iREQ1_DATA(fD1), .oREQ1_READY(fReady1),
        .oREQ1_DONE(fDone1), .oREQ1_ERR(fErr1),
        .oI2C_CTRL_CLK(fCtrl), .oI2C_DATA(fData), .oI2C_GO(fGo),
        .iI2C_END(fEnd), .iI2C_ACK(fAck), .oBUSY(fBusy)
    );

    // The fixed-priority instance talks to a controller that always acks on the first strobe.
    assign fEnd = fGo;

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Controller model: counts work-clock strobes while GO is high; two or more idle strobes mean a new command.
    initial begin : ctlModel
        int cnt;
        int zeros;
        int attempt;
        cnt = 0; zeros = 2; attempt = 0;
        iI2C_END = 1'b0; iI2C_ACK = 1'b0;
        forever begin
            @(posedge oI2C_CTRL_CLK or negedge iRST_N);
            #1;
            if (!iRST_N) begin
                cnt = 0; zeros = 2; attempt = 0;
                iI2C_END = 1'b0; iI2C_ACK = 1'b0;
            end else if (oI2C_GO) begin
                if (cnt == 0) begin
                    if (zeros >= 2) attempt = 0;
                    attempt++;
                    goRises++;
                    riseData = oI2C_DATA;
                end else begin
                    checkOutput("dataStable", 32'(oI2C_DATA), 32'(riseData));
                end
                cnt++;
                zeros = 0;
                lastGoLen = cnt;
                if (!ctlNeverEnd && cnt == ctlDelay) begin
                    iI2C_END = 1'b1;
                    iI2C_ACK = (attempt <= ctlNacks);
                end
            end else begin
                cnt = 0;
                zeros++;
                iI2C_END = 1'b0;
                iI2C_ACK = 1'b0;
            end
        end
    end

    task automatic waitCtrlRise(output bit ok);
        logic prev;
        int   n;
        ok = 0; n = 0; prev = oI2C_CTRL_CLK;
        while (!ok && n < 200) begin
            @(negedge iCLK);
            n++;
            if (!prev && oI2C_CTRL_CLK) ok = 1;
            prev = oI2C_CTRL_CLK;
        end
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (oBUSY && n < 3000) begin
            @(negedge iCLK);
            n++;
        end
        checkOutput(tag, 32'(oBUSY), 32'(0));
    endtask

    task automatic applyStimulus(input int req, input logic [23:0] word, input int delay,
                                 input int nacks, input bit never);
        int   n;
        bit   got;
        int   extraReady;
        int   otherDone;
        logic errSeen;
        logic expErr;
        int   expGos;
        int   expLen;
        ctlDelay = delay; ctlNacks = nacks; ctlNeverEnd = never; goRises = 0;
        expErr = never ? 1'b1 : (nacks > MAX_RETRY);
        expGos = never ? 1 : (((nacks < MAX_RETRY) ? nacks : MAX_RETRY) + 1);
        expLen = never ? TIMEOUT : delay;
        if (req == 0) begin iREQ0_DATA = word; iREQ0_VALID = 1'b1; end
        else          begin iREQ1_DATA = word; iREQ1_VALID = 1'b1; end
        got = 0; n = 0;
        while (!got && n < 4000) begin
            @(negedge iCLK);
            n++;
            if ((req == 0) ? oREQ0_READY : oREQ1_READY) got = 1;
        end
        checkOutput("readySeen", 32'(got), 32'(1));
        @(posedge iCLK);
        #1;
        if (req == 0) iREQ0_VALID = 1'b0; else iREQ1_VALID = 1'b0;
        checkOutput("latchedData", 32'(oI2C_DATA), 32'(word));
        got = 0; n = 0; extraReady = 0; otherDone = 0; errSeen = 1'bx;
        while (!got && n < 4000) begin
            @(negedge iCLK);
            n++;
            if ((req == 0) ? oREQ0_READY : oREQ1_READY) extraReady++;
            if ((req == 0) ? oREQ1_DONE : oREQ0_DONE) otherDone++;
            if ((req == 0) ? oREQ0_DONE : oREQ1_DONE) begin
                got = 1;
                errSeen = (req == 0) ? oREQ0_ERR : oREQ1_ERR;
            end
        end
        checkOutput("doneSeen", 32'(got), 32'(1));
        checkOutput("doneErr", 32'(errSeen), 32'(expErr));
        checkOutput("goCount", goRises, expGos);
        checkOutput("goLength", lastGoLen, expLen);
        checkOutput("goData", 32'(riseData), 32'(word));
        checkOutput("singleReady", extraReady, 0);
        checkOutput("otherDone", otherDone, 0);
        prio = (req == 0);
        waitIdle("busyIdle");
    endtask

    initial begin : main
        bit          ok1, ok2;
        longint      t1, t2;
        int          n, grants, g, cnt, busyCnt;
        logic [23:0] word0, word1;
        iRST_N = 1'b0;
        iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0; iREQ0_DATA = '0; iREQ1_DATA = '0;
        fV0 = 1'b0; fV1 = 1'b0; fD0 = '0; fD1 = '0; fAck = 1'b0;
        repeat (3) @(negedge iCLK);
        checkOutput("resetOutputs", 32'({oI2C_GO, oBUSY, oREQ0_READY, oREQ1_READY, oREQ0_DONE,
                    oREQ1_DONE, oREQ0_ERR, oREQ1_ERR, oI2C_CTRL_CLK}), 32'(0));
        checkOutput("resetData", 32'(oI2C_DATA), 32'(0));
        iRST_N = 1'b1;
        waitCtrlRise(ok1);
        t1 = $time;
        waitCtrlRise(ok2);
        t2 = $time;
        checkOutput("ctrlRise", 32'(ok1 && ok2), 32'(1));
        checkOutput("ctrlPeriod", 32'(t2 - t1), 2 * (CLK_F / I2C_F + 1) * CLKP);

        applyStimulus(0, 24'h34001A, 30, 0, 0);
        applyStimulus(1, 24'($urandom), $urandom_range(1, 6), 4, 0);
        applyStimulus(0, 24'($urandom), $urandom_range(1, 6), 2, 0);
        applyStimulus(1, 24'($urandom), 1, 0, 1);

        // Both requesters hold VALID: grants must alternate starting from the model's priority.
        word0 = 24'h340C00; word1 = 24'h400880;
        iREQ0_DATA = word0; iREQ1_DATA = word1;
        ctlDelay = $urandom_range(1, 3); ctlNacks = 0; ctlNeverEnd = 0;
        iREQ0_VALID = 1'b1; iREQ1_VALID = 1'b1;
        grants = 0; n = 0;
        while (grants < 6 && n < 4000) begin
            @(negedge iCLK);
            n++;
            if (oREQ0_READY || oREQ1_READY) begin
                g = oREQ1_READY ? 1 : 0;
                checkOutput("rrGrant", g, 32'(prio));
                checkOutput("rrOneReady", 32'(oREQ0_READY && oREQ1_READY), 32'(0));
                @(posedge iCLK);
                #1;
                checkOutput("rrData", 32'(oI2C_DATA), 32'((g == 1) ? word1 : word0));
                prio = (g == 0);
                grants++;
                if (grants == 6) begin iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0; end
            end
        end
        iREQ0_VALID = 1'b0; iREQ1_VALID = 1'b0;
        checkOutput("rrGrantCount", grants, 6);
        waitIdle("rrIdle");

        fD0 = word0; fD1 = word1; fV0 = 1'b1; fV1 = 1'b1;
        grants = 0; cnt = 0; n = 0;
        while (grants < 4 && n < 2000) begin
            @(negedge iCLK);
            n++;
            if (fReady1) cnt++;
            if (fReady0) grants++;
        end
        checkOutput("fixedReq0Grants", grants, 4);
        checkOutput("fixedReq1Starved", cnt, 0);
        @(posedge iCLK);
        #1;
        fV0 = 1'b0;
        cnt = 0; n = 0;
        while (cnt == 0 && n < 2000) begin
            @(negedge iCLK);
            n++;
            if (fReady1) cnt++;
        end
        checkOutput("fixedReq1After", cnt, 1);
        @(posedge iCLK);
        #1;
        fV1 = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus($urandom_range(0, 1), 24'($urandom), $urandom_range(1, 8),
                          $urandom_range(0, 4), ($urandom_range(0, 7) == 0));
        end

        // VALID pulsed between strobes must leave no trace.
        waitCtrlRise(ok1);
        iREQ0_DATA = 24'($urandom);
        iREQ0_VALID = 1'b1;
        cnt = 0; busyCnt = 0;
        repeat (3) begin
            @(negedge iCLK);
            cnt += int'(oREQ0_READY);
        end
        iREQ0_VALID = 1'b0;
        repeat (30) begin
            @(negedge iCLK);
            cnt += int'(oREQ0_READY);
            busyCnt += int'(oBUSY);
        end
        checkOutput("shortValidReady", cnt, 0);
        checkOutput("shortValidBusy", busyCnt, 0);

        // Reset in the middle of a transfer while req1 is queued behind it.
        ctlNeverEnd = 1; goRises = 0;
        iREQ0_DATA = 24'($urandom); iREQ0_VALID = 1'b1;
        ok1 = 0; n = 0;
        while (!ok1 && n < 200) begin
            @(negedge iCLK);
            n++;
            if (oREQ0_READY) ok1 = 1;
        end
        @(posedge iCLK);
        #1;
        iREQ0_VALID = 1'b0;
        word1 = 24'($urandom);
        iREQ1_DATA = word1; iREQ1_VALID = 1'b1;
        repeat (50) @(negedge iCLK);
        checkOutput("preResetActive", 32'({oI2C_GO, oBUSY}), 32'(3));
        #2;
        iRST_N = 1'b0;
        #1;
        checkOutput("asyncResetGoBusy", 32'({oI2C_GO, oBUSY}), 32'(0));
        checkOutput("asyncResetData", 32'(oI2C_DATA), 32'(0));
        cnt = 0;
        repeat (3) begin
            @(negedge iCLK);
            cnt += int'(oREQ0_DONE || oREQ1_DONE);
        end
        checkOutput("noDoneInReset", cnt, 0);
        iRST_N = 1'b1;
        prio = 1'b0;
        applyStimulus(1, word1, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_arbiter.md
Name: i2c_cmd_arbiter

Overview:
- Shares one I2C byte-transfer controller (24-bit {slave, sub-addr, data} word, GO/END/ACK handshake) between two command sources.
- Requester 0 is the power-up codec/decoder config sequencer. Requester 1 is the runtime register writer (volume, brightness, contrast).
- Generates the controller's slow work clock, arbitrates, issues GO, retries on NACK, enforces a timeout and reports per-command status.

Parameters:
- CLK_Freq, 50000000: iCLK frequency in Hz.
- I2C_Freq, 20000: divider rate. The work clock toggles every CLK_Freq/I2C_Freq+1 iCLK cycles.
- MAX_RETRY, 3: reissues after NACK before reporting error (0..7).
- TIMEOUT, 64: strobes allowed in WAIT before abort (1..255).
- RR_EN, 1: 1 = round-robin, 0 = fixed priority (req0 wins).

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iREQ0_VALID  in  1  requester 0 has a command
- iREQ0_DATA  in  24  requester 0 word {slave, sub, data}
- oREQ0_READY  out  1  one-cycle accept pulse
- oREQ0_DONE  out  1  one-cycle completion pulse
- oREQ0_ERR  out  1  status qualifier, valid with DONE (1 = failed)
- iREQ1_VALID, iREQ1_DATA, oREQ1_READY, oREQ1_DONE, oREQ1_ERR: same as requester 0, for requester 1
- oI2C_CTRL_CLK  out  1  controller work clock
- oI2C_DATA  out  24  word to controller
- oI2C_GO  out  1  transfer start/hold
- iI2C_END  in  1  controller transfer finished
- iI2C_ACK  in  1  controller ack result (0 = acked, 1 = NACK)
- oBUSY  out  1  high whenever the state is not IDLE

Behaviour:
- Reset: all outputs 0, divider 0, state IDLE, retry counter 0, timeout counter 0, rr pointer 0. Asynchronous assertion at any point, including mid-transfer, returns everything to reset values immediately; GO drops with it.
- Divider:
  - Counts 0..CLK_Freq/I2C_Freq.
  - At terminal count it clears and toggles oI2C_CTRL_CLK.
  - Internal strobe = the iCLK cycle in which oI2C_CTRL_CLK toggles 0->1.
  - All FSM transitions occur only on strobe cycles; END/ACK are sampled only then.
- Requester handshake:
  - VALID and DATA must be held until READY.
  - READY is a single iCLK pulse on the accepting strobe; DATA is latched in that cycle.
  - DONE and ERR pulse together for one iCLK cycle to the owning requester only.
  - A requester may raise VALID again in the cycle after DONE.
- Arbitration (in IDLE, on strobe):
  - RR_EN=0: req0 wins if valid.
  - RR_EN=1: if both valid, grant the requester opposite the last grantee. The pointer updates at DONE.
- States:
  - IDLE: on strobe with a winner, latch the word into oI2C_DATA, GO <= 1, clear retry and timeout counters, go to WAIT.
  - WAIT: each strobe with END=0 increments the timeout counter. When the count reaches TIMEOUT: GO <= 0, ERR=1, go to DONE. On strobe with END=1: GO <= 0, then:
    - ACK=0: go to DONE, ERR=0.
    - ACK=1 and retry < MAX_RETRY: retry++, go to GAP.
    - ACK=1 and retry = MAX_RETRY: go to DONE, ERR=1.
  - GAP: GO stays 0 for exactly one strobe so the controller can clear END. Then GO <= 1, timeout cleared, go to WAIT. oI2C_DATA is unchanged.
  - DONE: in the same strobe cycle, pulse DONE/ERR for the owner, update the rr pointer, go to IDLE.
- Timing and invariants:
  - Minimum gap between successive GO assertions is 2 strobes.
  - oI2C_DATA is stable whenever GO=1.
  - A requester dropping VALID before READY is ignored with no side effects.
  - VALID asserted while oBUSY=1 waits; it is never lost.
  - END=1 and timeout expiry on the same strobe: END has precedence.

Test Plan:
- Reset with CLK_Freq/I2C_Freq=4: oI2C_CTRL_CLK period is 10 iCLK cycles; all outputs 0; oBUSY=0.
- Req0 word 0x34_001A, model acks (END after 30 strobes, ACK=0) -> oI2C_DATA=0x34001A, GO high 30 strobes, REQ0_DONE=1 with ERR=0, exactly one READY pulse.
- Both valid every cycle, RR_EN=1, req0=0x34_0C00, req1=0x40_0880 -> grants alternate 0,1,0,1; RR_EN=0 -> req0 granted every time.
- Model NACKs always, MAX_RETRY=3 -> 4 GO assertions separated by one-strobe GAP, then DONE with ERR=1. Model NACKs twice then acks -> 3 GOs, ERR=0.
- END never returned, TIMEOUT=64 -> GO drops on the 64th WAIT strobe, DONE with ERR=1, FSM returns to IDLE.
- iRST_N pulsed low while in WAIT -> GO, oBUSY and oI2C_DATA go 0 asynchronously; no DONE pulse; after release a held req1 is accepted normally.
